bram_capture_writer: RTL
========================

BRAM_CAPTURE_WRITER -- requirements
Module: bram_capture_writer

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 14: buffer depth is 2^COUNT_WIDTH 32-bit words, split into two halves (half 0 low, half 1 high).
REQ-002 SHALL have clk, input, 1: single clock (FCLK_CLK0 domain); all logic on its rising edge.
REQ-003 SHALL have rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have arm, input, 1: level; high enables capture, low stops capture and clears status.
REQ-005 SHALL have mic_data, input, 32: packed PDM word from pdm_mic.
REQ-006 SHALL have mic_data_valid, input, 1: one-cycle strobe qualifying mic_data.
REQ-007 SHALL have half_ack, input, 2: one-cycle pulses; bit n releases half n after the PS has read it.
REQ-008 SHALL have addrb, output, 32: BRAM port-B byte address, equal to {zeros, word_idx, 2'b00}.
REQ-009 SHALL have dinb, output, 32: BRAM port-B write data.
REQ-010 SHALL have web, output, 4: BRAM port-B byte write enables.
REQ-011 SHALL have half_ready, output, 2: bit n is high while half n is full and not yet acknowledged.
REQ-012 SHALL have overflow, output, 1: sticky overrun flag.
REQ-013 SHALL have capturing, output, 1: high in state CAPTURE.

Function
REQ-014 SHALL implement states IDLE, CAPTURE and OVERRUN.
REQ-015 Transitions SHALL be:
- IDLE->CAPTURE on a rising edge of arm (arm high this cycle, low the previous cycle).
- Any state->IDLE whenever arm is low.
- CAPTURE->OVERRUN on an overrun (REQ-020).
REQ-016 Entering CAPTURE SHALL set word_idx=0, clear half_ready and clear overflow.
REQ-017 In CAPTURE, mic_data_valid=1 at cycle t SHALL produce on cycle t+1 only, with web=4'h0 on all other cycles:
- addrb={word_idx,2'b00};
- dinb=mic_data;
- web=4'hF.
REQ-018 After each accepted write, word_idx SHALL increment modulo 2^COUNT_WIDTH, wrapping from 2^COUNT_WIDTH-1 to 0.
REQ-019 A write to the last word of half n (index 2^(COUNT_WIDTH-1)-1 or 2^COUNT_WIDTH-1) SHALL set half_ready[n] on the same cycle web is asserted.
REQ-020 Overrun check: a valid strobe SHALL count as an overrun when it arrives while word_idx is the first word of half n, half_ready[n]=1 and half_ack[n]=0. On an overrun:
- no write is issued;
- overflow is set;
- the state moves to OVERRUN.
REQ-021 Simultaneous half_ack[n] and the overrun check for half n SHALL resolve in favour of the ack: the flag clears and the write proceeds.
REQ-022 half_ack[n] SHALL clear half_ready[n]; an ack for a half not ready SHALL be ignored.
REQ-023 half_ready[n] set and half_ack[n] on the same cycle SHALL leave half_ready[n]=1 (set wins).
REQ-024 In OVERRUN, the block SHALL:
- issue no writes;
- ignore mic_data_valid;
- hold overflow=1;
- continue to accept half_ack;
- stay in OVERRUN until arm goes low.
REQ-025 When arm goes low mid-capture (any state), the block SHALL on the next cycle:
- return to IDLE;
- force web=4'h0, overriding any write pending from the previous cycle's strobe;
- clear half_ready and overflow;
- keep word_idx until the next arm rising edge.
REQ-026 mic_data_valid in IDLE SHALL be ignored.
REQ-027 Maximum throughput SHALL be one write per clock; back-to-back strobes SHALL each be written in order.

Reset
REQ-028 While rstn=0, the block SHALL asynchronously hold:
- state=IDLE;
- word_idx=0;
- addrb=0, dinb=0, web=4'h0;
- half_ready=2'b00;
- overflow=0, capturing=0;
- the arm edge-detect register=0.
REQ-029 After rstn is released with arm already high, capture SHALL not start until arm is seen low and then high again.

Verification (COUNT_WIDTH=4: 16 words, halves of 8)
REQ-030 Arm rise, then 8 strobes carrying 0x100..0x107 -> web=F each following cycle; addrb=0x00..0x1C; half_ready=01 on the 8th write.
REQ-031 Continue with 8 more strobes, pulse half_ack=01 after the 12th -> half_ready=10 after the 16th; the 17th strobe writes addrb=0x00 and wraps.
REQ-032 Fill 16 words with no acks, then a 17th strobe -> no write; overflow=1; capturing=0; later strobes and acks give web=0; overflow stays 1.
REQ-033 17th strobe coincident with half_ack=01 -> write at addrb=0x00; overflow=0.
REQ-034 Drop arm on the cycle after a strobe -> web=0 on the following cycle; half_ready=00; state IDLE; re-arm restarts at addrb=0.
REQ-035 Assert rstn=0 mid-capture, asynchronously to clk -> all outputs reach their REQ-028 values without waiting for a clock edge.

Source files
------------

// File: rtl/bram_capture_writer.sv
// Streams PDM mic words into a ping-pong BRAM buffer through port B.
// Each half is flagged ready once full and must be acked by the PS before it is overwritten.
module bram_capture_writer #(
   parameter int unsigned COUNT_WIDTH = 14
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        arm,
   input  logic [31:0] mic_data,
   input  logic        mic_data_valid,
   input  logic [1:0]  half_ack,
   output logic [31:0] addrb,
   output logic [31:0] dinb,
   output logic [3:0]  web,
   output logic [1:0]  half_ready,
   output logic        overflow,
   output logic        capturing
);

   localparam int unsigned HalfW = COUNT_WIDTH - 1;

   typedef enum logic [1:0] {StIdle, StCapture, StOverrun} state_e;

   state_e                 state_q, state_d;
   logic                   arm_low_q;
   logic [COUNT_WIDTH-1:0] word_idx_q, word_idx_d;
   logic [31:0]            addrb_q, addrb_d;
   logic [31:0]            dinb_q, dinb_d;
   logic [3:0]             web_q, web_d;
   logic [1:0]             half_ready_q, half_ready_d;
   logic                   overflow_q, overflow_d;

   logic arm_rise, cur_half, first_word, last_word, accept, overrun, do_write;

   // Edge detect stores "arm was low"; a reset value of 0 means arm held high
   // through reset cannot look like a fresh rising edge.
   assign arm_rise   = arm & arm_low_q;
   assign cur_half   = word_idx_q[COUNT_WIDTH-1];
   assign first_word = (word_idx_q[HalfW-1:0] == '0);
   assign last_word  = &word_idx_q[HalfW-1:0];
   assign accept     = (state_q == StCapture) & arm & mic_data_valid;
   // An ack arriving with the strobe releases the half in time for the write.
   assign overrun    = accept & first_word & half_ready_q[cur_half] & ~half_ack[cur_half];
   assign do_write   = accept & ~overrun;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (arm_rise) state_d = StCapture;
         StCapture: if (overrun)  state_d = StOverrun;
         StOverrun: state_d = StOverrun;
         default:   state_d = StIdle;
      endcase
      if (!arm) state_d = StIdle;
   end

   always_comb begin
      capturing = (state_q == StCapture);
   end

   always_comb begin
      word_idx_d   = word_idx_q;
      addrb_d      = addrb_q;
      dinb_d       = dinb_q;
      web_d        = 4'h0;
      half_ready_d = half_ready_q & ~half_ack;
      overflow_d   = overflow_q;

      if (do_write) begin
         addrb_d    = 32'(word_idx_q) << 2;
         dinb_d     = mic_data;
         web_d      = 4'hF;
         word_idx_d = word_idx_q + COUNT_WIDTH'(1);
         // Set beats a same-cycle ack so a freshly filled half is never lost.
         if (last_word) half_ready_d[cur_half] = 1'b1;
      end

      if (overrun) overflow_d = 1'b1;

      if ((state_q == StIdle) && arm_rise) begin
         word_idx_d   = '0;
         half_ready_d = 2'b00;
         overflow_d   = 1'b0;
      end

      if (!arm) begin
         web_d        = 4'h0;
         half_ready_d = 2'b00;
         overflow_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         arm_low_q    <= 1'b0;
         word_idx_q   <= '0;
         addrb_q      <= '0;
         dinb_q       <= '0;
         web_q        <= 4'h0;
         half_ready_q <= 2'b00;
         overflow_q   <= 1'b0;
      end else begin
         arm_low_q    <= ~arm;
         word_idx_q   <= word_idx_d;
         addrb_q      <= addrb_d;
         dinb_q       <= dinb_d;
         web_q        <= web_d;
         half_ready_q <= half_ready_d;
         overflow_q   <= overflow_d;
      end
   end

   assign addrb      = addrb_q;
   assign dinb       = dinb_q;
   assign web        = web_q;
   assign half_ready = half_ready_q;
   assign overflow   = overflow_q;

endmodule
